crc_sched: RTL and testbench
============================

# crc_sched

Round-robin scheduler that shares one bit-serial CRC engine (the `crc` datapath, width/poly_width parameterised) among `NUM_REQ` requesters. Each requester hands over a message and a generator polynomial through a valid/ready handshake. The scheduler latches the selected job, starts the engine, and waits for completion or a timeout. It then returns the CRC remainder tagged with the requester ID. The block sits between client logic and the single shared CRC engine instance.

## Interface
- `NUM_REQ`: default 4. Number of requesters, ≥2.
- `width`: default 32. Message width; must match the engine.
- `poly_width`: default 9. Polynomial width; CRC result is `poly_width-1` bits.
- `TIMEOUT`: default 255. Maximum cycles spent in WAIT before aborting, ≥1.
- `ID_W`: derived, `$clog2(NUM_REQ)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in NUM_REQ: per-requester job request.
- `req_ready` out NUM_REQ: one-hot grant/accept; transfer occurs when `req_valid[i] & req_ready[i]`.
- `req_message` in NUM_REQ*width: requester i occupies bits `[i*width +: width]`.
- `req_poly` in NUM_REQ*poly_width: requester i occupies bits `[i*poly_width +: poly_width]`.
- `eng_start` out 1: one-cycle start pulse to the engine.
- `eng_message` out width: latched message, stable from ISSUE until the return to IDLE.
- `eng_poly` out poly_width: latched polynomial, stable over the same window.
- `eng_done` in 1: engine completion pulse, qualified only in WAIT.
- `eng_crc` in poly_width-1: engine result, sampled when `eng_done` is high in WAIT.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_id` out ID_W: requester index of the response.
- `resp_crc` out poly_width-1: CRC remainder; 0 when `resp_error` is set.
- `resp_error` out 1: timeout flag, qualified by `resp_valid`.
- `busy` out 1: high in every state except IDLE.

## Operation
FSM states are IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - If any `req_valid` is high, grant the first valid index searching upward from `last_grant+1` (mod NUM_REQ).
  - `req_ready` is a combinational one-hot of that index, active only in IDLE; all zero otherwise.
  - On the handshake edge: latch message, poly, and ID into `eng_message`, `eng_poly`, and `cur_id`, then go to ISSUE.
  - With no valid request, stay in IDLE.
- **ISSUE**
  - `eng_start`=1 for exactly this cycle.
  - Timeout counter cleared to 0.
  - Next state is WAIT, unconditionally.
- **WAIT**
  - If `eng_done`: capture `eng_crc` into `resp_crc`, set `resp_error`=0, go to RESP.
  - Else if counter == TIMEOUT-1: set `resp_crc`=0 and `resp_error`=1, go to RESP.
  - Else increment the counter.
  - If `eng_done` arrives on the timeout cycle, done wins.
- **RESP**
  - `resp_valid`=1 for one cycle, with `resp_id`=`cur_id`.
  - `last_grant` is updated to `cur_id`.
  - Next state is IDLE.
- **Boundary rules**
  - `eng_done` outside WAIT is ignored and changes no state.
  - A `req_valid` deasserted before its handshake is never granted.
  - Requests from non-granted requesters are held off and never dropped.
  - No starvation: each valid requester is served within NUM_REQ jobs.
- **Width rules**
  - The counter is wide enough for TIMEOUT-1.
  - ID arithmetic is modulo NUM_REQ, including the wrap from NUM_REQ-1 to 0 when NUM_REQ is not a power of two.

## Timing
- **Reset values**: state=IDLE, `last_grant`=NUM_REQ-1 so requester 0 has first priority.
  - All outputs are 0: `req_ready`, `eng_start`, `eng_message`, `eng_poly`, `resp_valid`, `resp_id`, `resp_crc`, `resp_error`, `busy`.
  - Reset takes effect immediately, without waiting for a clock edge.
- **Handshake**: accepted at edge T0. `eng_start` is high during cycle T0+1 (ISSUE).
- **Normal completion**: `eng_done` high in cycle T0+1+d, with d≥1 (first WAIT cycle is T0+2). `resp_valid` is high in cycle T0+2+d.
- **Timeout**: WAIT lasts exactly TIMEOUT cycles, covering T0+2 through T0+1+TIMEOUT. `resp_valid` is high in T0+2+TIMEOUT.
- **Back-to-back**: the earliest next grant is the cycle after RESP. Minimum job period is 4 + d − 1 cycles.
- **Reset mid-job**: any in-flight job is discarded with no response. A late `eng_done` after reset is ignored.

## Test plan
- **Single job**: requester 2, message 32'h12345678, poly 9'h107; engine model returns `eng_done` with 8'h5C three cycles after start.
  - `req_ready`=4'b0100 for one cycle.
  - `eng_start` one cycle later, with those exact message and poly values.
  - `resp_valid` with `resp_id`=2, `resp_crc`=8'h5C, `resp_error`=0, exactly one cycle after done.
- **Fairness**: all four `req_valid` held high from reset.
  - Grant order is 0,1,2,3,0,1.
  - Each `resp_id` matches its grant and carries the poly/message of that requester.
- **Timeout**: TIMEOUT=16; engine never asserts done.
  - `resp_valid`, `resp_error`=1, `resp_crc`=0 at T0+18.
  - Next request is served normally afterwards.
- **Done on timeout cycle**: `eng_done` in the last WAIT cycle with 8'hA5.
  - `resp_error`=0, `resp_crc`=8'hA5.
- **Reset mid-WAIT**: assert `reset` between clock edges during WAIT.
  - Outputs are 0 immediately.
  - A subsequent `eng_done` pulse gives no response.
  - The first post-reset grant goes to requester 0 when 0 and 3 are both valid.
- **Spurious/withdrawn**: `eng_done` pulsed in IDLE, and requester 1 drops `req_valid` before its grant.
  - No state change and no response for requester 1.
  - Requester 3, still valid, is granted next.

Source files
------------

// File: rtl/crc_sched.sv
// crc_sched: round-robin arbiter that shares one bit-serial CRC engine among
// NUM_REQ requesters, with per-job timeout and ID-tagged responses.
`default_nettype none

module crc_sched #(
  parameter  int NUM_REQ    = 4,
  parameter  int width      = 32,
  parameter  int poly_width = 9,
  parameter  int TIMEOUT    = 255,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*width-1:0]      req_message,
  input  logic [NUM_REQ*poly_width-1:0] req_poly,
  output logic                          eng_start,
  output logic [width-1:0]              eng_message,
  output logic [poly_width-1:0]         eng_poly,
  input  logic                          eng_done,
  input  logic [poly_width-2:0]         eng_crc,
  output logic                          resp_valid,
  output logic [ID_W-1:0]               resp_id,
  output logic [poly_width-2:0]         resp_crc,
  output logic                          resp_error,
  output logic                          busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       last_grant_q, last_grant_d;
  logic [ID_W-1:0]       cur_id_q, cur_id_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [width-1:0]      msg_q, msg_d;
  logic [poly_width-1:0] poly_q, poly_d;
  logic [poly_width-2:0] crc_q, crc_d;
  logic                  err_q, err_d;

  logic                  grant_found;
  logic [ID_W-1:0]       grant_idx;

  // Explicit modulo keeps the wrap correct when NUM_REQ is not a power of two.
  function automatic logic [ID_W-1:0] wrap_id(input int v);
    return ID_W'(v % NUM_REQ);
  endfunction

  // Scan offsets from far to near so the nearest valid index after last_grant wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[wrap_id(int'(last_grant_q) + k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_id(int'(last_grant_q) + k);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_id_d     = cur_id_q;
    cnt_d        = cnt_q;
    msg_d        = msg_q;
    poly_d       = poly_q;
    crc_d        = crc_q;
    err_d        = err_q;
    req_ready    = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_found && !reset) begin
          req_ready[grant_idx] = 1'b1;
          msg_d    = req_message[int'(grant_idx)*width +: width];
          poly_d   = req_poly[int'(grant_idx)*poly_width +: poly_width];
          cur_id_d = grant_idx;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done) begin
          crc_d   = eng_crc;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          crc_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        last_grant_d = cur_id_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      cur_id_q     <= '0;
      cnt_q        <= '0;
      msg_q        <= '0;
      poly_q       <= '0;
      crc_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_id_q     <= cur_id_d;
      cnt_q        <= cnt_d;
      msg_q        <= msg_d;
      poly_q       <= poly_d;
      crc_q        <= crc_d;
      err_q        <= err_d;
    end
  end

  assign eng_start   = (state_q == S_ISSUE);
  assign eng_message = msg_q;
  assign eng_poly    = poly_q;
  assign resp_valid  = (state_q == S_RESP);
  assign resp_id     = resp_valid ? cur_id_q : '0;
  assign resp_crc    = crc_q;
  assign resp_error  = err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_crc_sched.sv
// tb_crc_sched: directed and randomized jobs checked against a transaction-level
// round-robin reference model; the bench also plays the CRC engine.
`default_nettype none

module tb_crc_sched;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int PW = 9;
  localparam int CW = PW - 1;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_message;
  logic [N*PW-1:0] req_poly;
  logic            eng_start;
  logic [W-1:0]    eng_message;
  logic [PW-1:0]   eng_poly;
  logic            eng_done;
  logic [CW-1:0]   eng_crc;
  logic            resp_valid;
  logic [1:0]      resp_id;
  logic [CW-1:0]   resp_crc;
  logic            resp_error;
  logic            busy;

  crc_sched #(.NUM_REQ(N), .width(W), .poly_width(PW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_message(req_message), .req_poly(req_poly),
    .eng_start(eng_start), .eng_message(eng_message), .eng_poly(eng_poly),
    .eng_done(eng_done), .eng_crc(eng_crc),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_crc(resp_crc),
    .resp_error(resp_error), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int model_last;
  logic [W-1:0]  msg  [N];
  logic [PW-1:0] poly [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      req_message[i*W +: W]   = msg[i];
      req_poly[i*PW +: PW]    = poly[i];
    end
  endtask

  // Reference arbitration: first valid index after the last served one, modulo N.
  function automatic int model_grant(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(model_last + k) % N]) return (model_last + k) % N;
    end
    return 0;
  endfunction

  task automatic chk_zero(input string pfx);
    chk({pfx, "_ready"}, req_ready, 0);
    chk({pfx, "_start"}, eng_start, 0);
    chk({pfx, "_msg"},   eng_message, 0);
    chk({pfx, "_poly"},  eng_poly, 0);
    chk({pfx, "_rvalid"}, resp_valid, 0);
    chk({pfx, "_rid"},   resp_id, 0);
    chk({pfx, "_rcrc"},  resp_crc, 0);
    chk({pfx, "_rerr"},  resp_error, 0);
    chk({pfx, "_busy"},  busy, 0);
  endtask

  // One complete job from an IDLE negedge. Engine answers in WAIT cycle d
  // (1-based); d > TO means the engine stays silent and the job times out.
  task automatic do_job(input int d, input logic [CW-1:0] crc,
                        input logic [N-1:0] mid_set, input logic [N-1:0] mid_clr);
    int            id;
    logic [W-1:0]  em;
    logic [PW-1:0] ep;
    bit            err;
    #1;
    id = model_grant(req_valid);
    em = msg[id];
    ep = poly[id];
    chk("grant_ready", req_ready, 64'(4'b0001 << id));
    chk("grant_busy", busy, 0);
    @(negedge clk);
    chk("issue_start", eng_start, 1);
    chk("issue_msg", eng_message, em);
    chk("issue_poly", eng_poly, ep);
    chk("issue_ready", req_ready, 0);
    chk("issue_busy", busy, 1);
    msg[id]  = W'($urandom);
    poly[id] = PW'($urandom);
    drive_bus();
    req_valid = req_valid | mid_set;
    err = 1'b1;
    for (int w = 1; w <= TO; w++) begin
      @(negedge clk);
      chk("wait_start", eng_start, 0);
      chk("wait_rvalid", resp_valid, 0);
      chk("wait_msg", eng_message, em);
      chk("wait_poly", eng_poly, ep);
      chk("wait_ready", req_ready, 0);
      eng_crc = CW'($urandom);
      if (w == d) begin
        eng_done = 1'b1;
        eng_crc  = crc;
        err      = 1'b0;
      end
      if (w == d || w == TO) begin
        req_valid = req_valid & ~mid_clr;
        break;
      end
    end
    @(negedge clk);
    eng_done = 1'b0;
    chk("resp_valid", resp_valid, 1);
    chk("resp_id", resp_id, id);
    chk("resp_crc", resp_crc, err ? 0 : crc);
    chk("resp_error", resp_error, err);
    chk("resp_msg", eng_message, em);
    chk("resp_ready", req_ready, 0);
    model_last = id;
    @(negedge clk);
    chk("post_rvalid", resp_valid, 0);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    eng_done  = 1'b0;
    eng_crc   = '0;
    for (int i = 0; i < N; i++) begin
      msg[i]  = W'($urandom);
      poly[i] = PW'($urandom);
    end
    drive_bus();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset      = 1'b0;
    model_last = N - 1;

    // Single job: requester 2, engine answers three cycles after start.
    msg[2]  = 32'h12345678;
    poly[2] = 9'h107;
    drive_bus();
    req_valid = 4'b0100;
    do_job(3, 8'h5C, '0, '0);
    req_valid = '0;

    // Fairness: all requesters valid from reset.
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    reset      = 1'b0;
    model_last = N - 1;
    repeat (6) do_job($urandom_range(1, 5), CW'($urandom), '0, '0);

    // Timeout, then a normal job.
    req_valid = 4'b0010;
    do_job(TO + 1, CW'($urandom), '0, '0);
    req_valid = 4'b0001;
    do_job(2, CW'($urandom), '0, '0);

    // Done arriving on the last WAIT cycle wins over the timeout.
    req_valid = 4'b1000;
    do_job(TO, 8'hA5, '0, '0);

    // Reset asserted between edges in the middle of WAIT.
    req_valid = 4'b0100;
    #1;
    chk("mid_ready", req_ready, 64'(4'b0001 << model_grant(req_valid)));
    @(negedge clk);
    chk("mid_start", eng_start, 1);
    req_valid = '0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk_zero("rst_mid");
    req_valid = 4'b1001;
    #1;
    chk("rst_hold_ready", req_ready, 0);
    req_valid = '0;
    @(negedge clk);
    reset      = 1'b0;
    model_last = N - 1;
    eng_done   = 1'b1;
    eng_crc    = 8'h3C;
    @(negedge clk);
    eng_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_done_rvalid", resp_valid, 0);
      chk("late_done_busy", busy, 0);
      @(negedge clk);
    end
    req_valid = 4'b1001;
    do_job(2, CW'($urandom), '0, '0);
    req_valid = '0;

    // Spurious done in IDLE, then requester 1 withdraws while held off.
    eng_done = 1'b1;
    eng_crc  = 8'hA5;
    @(negedge clk);
    eng_done = 1'b0;
    chk("spur_busy", busy, 0);
    chk("spur_rvalid", resp_valid, 0);
    @(negedge clk);
    chk("spur_rvalid2", resp_valid, 0);
    req_valid = 4'b1100;
    do_job(2, CW'($urandom), 4'b0010, 4'b0010);
    req_valid = req_valid & ~4'b0100;
    do_job(1, CW'($urandom), '0, '0);

    // Randomized traffic with held-off and withdrawn requests.
    for (int j = 0; j < 40; j++) begin
      req_valid = N'($urandom_range(1, 15));
      do_job($urandom_range(1, TO + 3), CW'($urandom),
             N'($urandom_range(0, 15)), N'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
